// File: rtl/spi_sensor_master.sv
// Mode-3 SPI master for register-level sensor access: one command byte {rw, reg_addr}
// followed by a 1..MAX_BYTES burst, with programmable SCK divider and per-byte handshakes.
module spi_sensor_master #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 8,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       reg_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  output logic             wr_next,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int               CNT_W     = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(2 * CLK_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD,
    GUARD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;         // cycles within the current half-period / hold / guard
  logic [3:0]       half;        // half-period index within a byte, even = SCK low
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic [LEN_W-1:0] bytes_left;
  logic             in_cmd;
  logic             read_txn;
  logic [LEN_W-1:0] eff_len;
  logic [7:0]       next_byte;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    eff_len = len;
    if (len == '0) begin
      eff_len = LEN_ONE;
    end else if (len > MAX_LEN) begin
      eff_len = MAX_LEN;
    end
  end

  assign next_byte = read_txn ? 8'h00 : wr_data;

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      half       <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bytes_left <= '0;
      in_cmd     <= 1'b0;
      read_txn   <= 1'b0;
      wr_next    <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cs_n       <= 1'b1;
      sck        <= 1'b1;
      mosi       <= 1'b0;
    end else begin
      wr_next  <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            tx_sr      <= {rw, reg_addr};
            read_txn   <= rw;
            bytes_left <= eff_len;
            in_cmd     <= 1'b1;
            busy       <= 1'b1;
            cs_n       <= 1'b0;
            cnt        <= '0;
            state      <= SETUP;
          end
        end

        // CS setup time; its last edge is also the first SCK falling edge.
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            half  <= '0;
            sck   <= 1'b0;
            mosi  <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b0};
            state <= SHIFT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt  <= '0;
            half <= half + 4'd1;
            if (!half[0]) begin
              sck   <= 1'b1;
              rx_sr <= {rx_sr[6:0], miso};
              if (half == 4'd14) begin
                state <= NEXT;
              end
            end else begin
              sck   <= 1'b0;
              mosi  <= tx_sr[7];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // First cycle of the byte's last high half-period: hand off the finished byte
        // and load the next one without stretching SCK.
        NEXT: begin
          in_cmd <= 1'b0;
          if (!in_cmd && read_txn) begin
            rd_data  <= rx_sr;
            rd_valid <= 1'b1;
          end
          if (bytes_left != '0) begin
            bytes_left <= bytes_left - LEN_ONE;
            wr_next    <= !read_txn;
            state      <= SHIFT;
            if (CLK_DIV == 1) begin
              sck   <= 1'b0;
              mosi  <= next_byte[7];
              tx_sr <= {next_byte[6:0], 1'b0};
              half  <= '0;
              cnt   <= '0;
            end else begin
              tx_sr <= next_byte;
              cnt   <= CNT_ONE;
            end
          end else begin
            cnt   <= '0;
            state <= HOLD;
          end
        end

        // Remainder of the last high half-period plus CLK_DIV cycles of CS hold.
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
            done  <= 1'b1;
            state <= GUARD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        GUARD: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sensor_master.sv
// Bench for spi_sensor_master: three instances (CLK_DIV 2, 4, 1) driven by directed and
// random transactions, checked against a transaction-level model of the SPI frame.
module tb_spi_sensor_master;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start    [NI];
  logic       rw       [NI];
  logic [6:0] reg_addr [NI];
  logic [3:0] len      [NI];
  logic [7:0] wr_data  [NI];
  logic       miso     [NI];
  logic       wr_next  [NI];
  logic [7:0] rd_data  [NI];
  logic       rd_valid [NI];
  logic       busy     [NI];
  logic       done     [NI];
  logic       cs_n     [NI];
  logic       sck      [NI];
  logic       mosi     [NI];

  int checks   = 0;
  int failures = 0;

  logic [7:0] wr_q[$];
  logic [7:0] sl_q[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_sensor_master #(
      .CLK_DIV  (g == 0 ? 2 : (g == 1 ? 4 : 1)),
      .MAX_BYTES(8)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start[g]),
      .rw      (rw[g]),
      .reg_addr(reg_addr[g]),
      .len     (len[g]),
      .wr_data (wr_data[g]),
      .wr_next (wr_next[g]),
      .rd_data (rd_data[g]),
      .rd_valid(rd_valid[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .cs_n    (cs_n[g]),
      .sck     (sck[g]),
      .mosi    (mosi[g]),
      .miso    (miso[g])
    );
  end

  function automatic int div_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input int k, input string tag);
    check($sformatf("%s_cs_n[%0d]", tag, k), cs_n[k], 1'b1);
    check($sformatf("%s_sck[%0d]", tag, k), sck[k], 1'b1);
    check($sformatf("%s_mosi[%0d]", tag, k), mosi[k], 1'b0);
    check($sformatf("%s_busy[%0d]", tag, k), busy[k], 1'b0);
    check($sformatf("%s_done[%0d]", tag, k), done[k], 1'b0);
    check($sformatf("%s_rd_valid[%0d]", tag, k), rd_valid[k], 1'b0);
    check($sformatf("%s_wr_next[%0d]", tag, k), wr_next[k], 1'b0);
    check($sformatf("%s_rd_data[%0d]", tag, k), rd_data[k], 8'h00);
  endtask

  task automatic fill_random();
    wr_q.delete();
    sl_q.delete();
    for (int i = 0; i < 8; i++) begin
      wr_q.push_back(8'($urandom));
      sl_q.push_back(8'($urandom));
    end
  endtask

  // One full transaction on instance k, observed cycle by cycle at the falling clk edge.
  // With hold set, start stays high and the automatic second transaction is also checked.
  task automatic run_txn(input int k, input logic t_rw, input logic [6:0] t_addr,
                         input logic [3:0] t_len, input bit hold);
    int d, n, c, budget, exp_done;
    int low_cnt, cs_fall_c, cs_rise_c, refall_c, first_fall_c, done_cnt, done_c, busy_fall_c;
    int wr_cnt, wr_idx, last_rise_c, gap_err, f;
    bit timed_out;
    logic prev_sck, prev_cs;
    logic mosi_bits[$];
    logic [7:0] rd_got[$];
    logic [7:0] tmp, e;
    string tg;

    d  = div_of(k);
    n  = (t_len == 0) ? 1 : ((t_len > 8) ? 8 : int'(t_len));
    tg = $sformatf("k%0d_rw%0d_len%0d", k, t_rw, t_len);
    exp_done = 1 + 2 * d + (n + 1) * 16 * d;
    budget   = exp_done + 2 * d + 20;
    low_cnt = 0; cs_fall_c = -1; cs_rise_c = -1; refall_c = -1; first_fall_c = -1;
    done_cnt = 0; done_c = -1; busy_fall_c = -1; wr_cnt = 0; wr_idx = 0;
    last_rise_c = -1; gap_err = 0; f = 0; timed_out = 1'b0;

    @(negedge clk);
    rw[k]       = t_rw;
    reg_addr[k] = t_addr;
    len[k]      = t_len;
    wr_data[k]  = wr_q[0];
    start[k]    = 1'b1;
    prev_sck    = sck[k];
    prev_cs     = cs_n[k];
    c = 0;

    while (1) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        if (!hold) start[k] = 1'b0;
        rw[k]       = 1'($urandom);
        reg_addr[k] = 7'($urandom);
        len[k]      = 4'($urandom);
      end
      if (prev_cs && !cs_n[k]) begin
        if (cs_fall_c < 0) cs_fall_c = c;
        else if (busy_fall_c >= 0 && refall_c < 0) refall_c = c;
      end
      if (!prev_cs && cs_n[k] && cs_rise_c < 0) cs_rise_c = c;
      if (!cs_n[k] && cs_rise_c < 0) low_cnt++;
      if (done[k] && busy_fall_c < 0) begin
        done_cnt++;
        done_c = c;
      end
      if (done_c >= 0 && !busy[k] && busy_fall_c < 0) busy_fall_c = c;
      if (busy_fall_c < 0) begin
        if (wr_next[k]) begin
          wr_cnt++;
          wr_idx++;
          wr_data[k] = (wr_idx < wr_q.size()) ? wr_q[wr_idx] : 8'($urandom);
        end
        if (rd_valid[k]) rd_got.push_back(rd_data[k]);
        if (!cs_n[k] && !prev_sck && sck[k]) begin
          mosi_bits.push_back(mosi[k]);
          if (last_rise_c >= 0 && (c - last_rise_c) != 2 * d) gap_err++;
          last_rise_c = c;
        end
        if (!cs_n[k] && prev_sck && !sck[k]) begin
          if (first_fall_c < 0) first_fall_c = c;
          // Sensor model: command-phase bits are junk, then the data bytes MSB first.
          if (f >= 8 && (f - 8) / 8 < sl_q.size()) begin
            tmp = sl_q[(f - 8) / 8];
            miso[k] = tmp[7 - ((f - 8) % 8)];
          end else begin
            miso[k] = 1'($urandom);
          end
          f++;
        end
      end
      prev_sck = sck[k];
      prev_cs  = cs_n[k];
      if (!hold && busy_fall_c >= 0) break;
      if (hold && refall_c >= 0) break;
      if (c >= budget) begin
        timed_out = 1'b1;
        break;
      end
    end

    check({tg, "_timeout"}, timed_out, 1'b0);
    check({tg, "_cs_fall"}, cs_fall_c, 1);
    check({tg, "_first_sck_fall"}, first_fall_c, 1 + d);
    check({tg, "_cs_low_cycles"}, low_cnt, 2 * d + (n + 1) * 16 * d);
    check({tg, "_cs_rise"}, cs_rise_c, exp_done);
    check({tg, "_done_count"}, done_cnt, 1);
    check({tg, "_done_cycle"}, done_c, exp_done);
    check({tg, "_busy_fall"}, busy_fall_c, exp_done + d);
    check({tg, "_sck_period"}, gap_err, 0);
    check({tg, "_bit_count"}, mosi_bits.size(), 8 * (n + 1));
    for (int i = 0; i <= n; i++) begin
      tmp = 8'h00;
      if (8 * (i + 1) <= mosi_bits.size()) begin
        for (int j = 0; j < 8; j++) tmp = {tmp[6:0], mosi_bits[8 * i + j]};
      end
      e = (i == 0) ? {t_rw, t_addr} : (t_rw ? 8'h00 : wr_q[i - 1]);
      check($sformatf("%s_mosi_byte%0d", tg, i), tmp, e);
    end
    check({tg, "_wr_next_count"}, wr_cnt, t_rw ? 0 : n);
    check({tg, "_rd_valid_count"}, rd_got.size(), t_rw ? n : 0);
    if (t_rw) begin
      for (int i = 0; i < rd_got.size() && i < n; i++)
        check($sformatf("%s_rd_byte%0d", tg, i), rd_got[i], sl_q[i]);
      check({tg, "_rd_data_hold"}, rd_data[k], sl_q[n - 1]);
    end

    if (hold) begin
      int w, dn;
      check({tg, "_hold_refall_seen"}, refall_c > 0, 1'b1);
      check({tg, "_hold_refall_after_idle"}, refall_c > busy_fall_c, 1'b1);
      check({tg, "_hold_cs_high_ge_div"}, (refall_c - cs_rise_c) >= d, 1'b1);
      start[k] = 1'b0;
      w = 0;
      dn = 0;
      while (w < 16 * d * 9 + 8 * d + 50) begin
        @(negedge clk);
        w++;
        if (done[k]) dn++;
        if (!busy[k]) break;
      end
      check({tg, "_hold_second_done"}, dn, 1);
      check({tg, "_hold_second_idle"}, busy[k], 1'b0);
    end
  endtask

  initial begin
    int dn;
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0; rw[k] = 1'b0; reg_addr[k] = '0; len[k] = '0;
      wr_data[k] = '0; miso[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check_reset_values(k, "por");
    reset = 1'b0;

    // Single write at CLK_DIV=2: 0x74 then 0x27, 68 cycles of cs_n low.
    fill_random();
    wr_q[0] = 8'h27;
    run_txn(0, 1'b0, 7'h74, 4'd1, 1'b0);

    // Burst read at CLK_DIV=4: command 0xFA, sensor returns 0x5A, 0xC3.
    fill_random();
    sl_q[0] = 8'h5A;
    sl_q[1] = 8'hC3;
    run_txn(1, 1'b1, 7'h7A, 4'd2, 1'b0);

    // start held high across the whole transaction.
    fill_random();
    run_txn(0, 1'b1, 7'h11, 4'd2, 1'b1);

    // Length clamping.
    fill_random();
    run_txn(0, 1'b0, 7'h22, 4'd0, 1'b0);
    fill_random();
    run_txn(0, 1'b0, 7'h23, 4'd15, 1'b0);

    // Reset in the middle of the 3rd bit of the first data byte (CLK_DIV=2).
    @(negedge clk);
    rw[0] = 1'b0; reg_addr[0] = 7'h40; len[0] = 4'd2; wr_data[0] = 8'h3C; start[0] = 1'b1;
    dn = 0;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (c == 1) start[0] = 1'b0;
      if (done[0]) dn++;
    end
    check("rst_mid_cs_low", cs_n[0], 1'b0);
    check("rst_mid_sck_low", sck[0], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_cs_n", cs_n[0], 1'b1);
    check("rst_mid_sck", sck[0], 1'b1);
    check("rst_mid_mosi", mosi[0], 1'b0);
    check("rst_mid_busy", busy[0], 1'b0);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    check("rst_mid_no_done", dn, 0);
    fill_random();
    run_txn(0, 1'b0, 7'h55, 4'd3, 1'b0);

    // CLK_DIV=1 back-to-back read of 3 bytes.
    fill_random();
    run_txn(2, 1'b1, 7'h3C, 4'd3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      fill_random();
      run_txn(i % NI, 1'($urandom), 7'($urandom), 4'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
